// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop, LSB first.
// Computes {cout, sum} = a + b + cin over WIDTH cycles with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] ws_q;
    logic [WIDTH-1:0] ws_d;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             bit_s;
    logic             bit_c;

    // Full-adder cell on the current LSBs; new sum bit enters the working register at the MSB.
    always_comb begin
        bit_s = sa_q[0] ^ sb_q[0] ^ carry_q;
        bit_c = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
        ws_d = ws_q >> 1;
        ws_d[WIDTH-1] = bit_s;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            ws_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        ws_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    ws_q    <= ws_d;
                    carry_q <= bit_c;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        // Result is published only here, so sum/cout stay stable while shifting.
                        sum_q   <= ws_d;
                        cout_q  <= bit_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one add on the 8-bit DUT from IDLE; return the result seen with done and the
    // number of edges after the accepting edge at which done became visible (-1: never).
    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        output logic [7:0] so, output logic co, output int lat);
        a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = -1; so = 8'h00; co = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                lat = i; so = sum8; co = cout8;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic run1(input logic ai, input logic bi, input logic ci,
                        output logic so, output logic co, output int lat);
        a1 = ai; b1 = bi; cin1 = ci; start1 = 1'b1;
        step();
        start1 = 1'b0;
        lat = -1; so = 1'b0; co = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done1) begin
                lat = i; so = sum1[0]; co = cout1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, sum8, cout8} !== 11'h000) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all zero",
                     busy8, done8, sum8, cout8);
        end
        n_cmp++;
        if ({busy1, done1, sum1, cout1} !== 4'h0) begin
            n_err++;
            $display("FAIL reset1: got busy=%b done=%b sum=%h cout=%b, want all zero",
                     busy1, done1, sum1, cout1);
        end
    endtask

    task automatic test_basic();
        int busy_cnt, done_at;
        logic [7:0] s;
        logic c;
        logic busy_at_done;
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        busy_cnt = 0; done_at = -1; s = 8'h00; c = 1'b0; busy_at_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                done_at = i + 1; s = sum8; c = cout8; busy_at_done = busy8;
                break;
            end
            if (busy8) busy_cnt++;
            step();
        end
        n_cmp++;
        if (busy_cnt != 8) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", busy_cnt);
        end
        n_cmp++;
        if (done_at != 9) begin
            n_err++;
            $display("FAIL basic_done_latency: got %0d edges, want 9", done_at);
        end
        n_cmp++;
        if (s !== 8'h7F || c !== 1'b0 || busy_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got sum=%h cout=%b busy=%b, want 7f 0 0",
                     s, c, busy_at_done);
        end
        step();
        n_cmp++;
        if (done8 !== 1'b0 || sum8 !== 8'h7F) begin
            n_err++;
            $display("FAIL basic_done_width: got done=%b sum=%h, want 0 7f", done8, sum8);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s;
        logic c;
        int lat;
        run8(8'hFF, 8'h01, 1'b0, s, c, lat);
        n_cmp++;
        if (s !== 8'h00 || c !== 1'b1 || lat != 8) begin
            n_err++;
            $display("FAIL carry_ff_01: got sum=%h cout=%b lat=%0d, want 00 1 8", s, c, lat);
        end
        run8(8'hFF, 8'hFF, 1'b1, s, c, lat);
        n_cmp++;
        if (s !== 8'hFF || c !== 1'b1 || lat != 8) begin
            n_err++;
            $display("FAIL carry_ff_ff_1: got sum=%h cout=%b lat=%0d, want ff 1 8", s, c, lat);
        end
    endtask

    // Previous result is ff/1; a second start and noisy operands during SHIFT must not matter.
    task automatic test_ignore_start();
        int ndone, held_bad, busy_after;
        logic [7:0] s;
        logic c;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        ndone = 0; held_bad = 0; busy_after = 0; s = 8'h00; c = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (done8) begin
                ndone++;
                if (ndone == 1) begin s = sum8; c = cout8; end
            end else if (ndone == 0 && (sum8 !== 8'hFF || cout8 !== 1'b1)) begin
                held_bad++;
            end else if (ndone > 0 && busy8) begin
                busy_after++;
            end
            if (i == 2) begin
                a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
            end else if (i > 2 && i < 8) begin
                a8 = ~a8; b8 = ~b8; cin8 = ~cin8;
            end
            if (i == 6) start8 = 1'b0;
            step();
        end
        n_cmp++;
        if (ndone != 1 || busy_after != 0) begin
            n_err++;
            $display("FAIL ignore_start: got %0d done pulses, %0d busy after, want 1 0",
                     ndone, busy_after);
        end
        n_cmp++;
        if (s !== 8'h30 || c !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: got sum=%h cout=%b, want 30 0", s, c);
        end
        n_cmp++;
        if (held_bad != 0) begin
            n_err++;
            $display("FAIL hold_previous: got %0d cycles with changed sum, want 0", held_bad);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        logic [7:0] s;
        logic c;
        int lat;
        a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, sum8, cout8} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b, want all zero",
                     busy8, done8, sum8, cout8);
        end
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) stray++;
            step();
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d active cycles, want 0", stray);
        end
        run8(8'h01, 8'h01, 1'b0, s, c, lat);
        n_cmp++;
        if (s !== 8'h02 || c !== 1'b0 || lat != 8) begin
            n_err++;
            $display("FAIL reset_fresh: got sum=%h cout=%b lat=%0d, want 02 0 8", s, c, lat);
        end
    endtask

    task automatic test_back_to_back();
        int nd, bad, last;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        nd = 0; bad = 0; last = -1;
        for (int i = 0; i < 45; i++) begin
            step();
            if (done8) begin
                nd++;
                if (sum8 !== 8'h00 || cout8 !== 1'b1) bad++;
                if (last >= 0 && i - last != 10) bad++;
                last = i;
            end
        end
        start8 = 1'b0;
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if (nd != 4 || bad != 0) begin
            n_err++;
            $display("FAIL back_to_back: got %0d pulses %0d bad, want 4 0", nd, bad);
        end
    endtask

    task automatic test_random8();
        logic [7:0] ai, bi, s;
        logic ci, c;
        logic [8:0] exp9;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            ai = 8'($urandom_range(0, 255));
            bi = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
            run8(ai, bi, ci, s, c, lat);
            n_cmp++;
            if ({c, s} !== exp9 || lat != 8) begin
                n_err++;
                $display("FAIL rand8 %h+%h+%b: got %h lat=%0d, want %h lat=8",
                         ai, bi, ci, {c, s}, lat, exp9);
            end
        end
    endtask

    task automatic test_random1();
        logic ai, bi, ci, s, c;
        logic [1:0] exp2;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            ai = 1'($urandom_range(0, 1));
            bi = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            exp2 = {1'b0, ai} + {1'b0, bi} + {1'b0, ci};
            run1(ai, bi, ci, s, c, lat);
            n_cmp++;
            if ({c, s} !== exp2 || lat != 1) begin
                n_err++;
                $display("FAIL rand1 %b+%b+%b: got %b lat=%0d, want %b lat=1",
                         ai, bi, ci, {c, s}, lat, exp2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random8();
        test_random1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
